// File: rtl/sprite_line_fetch_pkg.sv
// Shared constants and FSM encoding for the sprite pipeline blocks.
package sprite_line_fetch_pkg;

  localparam int SPR_W  = 64;
  localparam int SPR_H  = 64;
  localparam int ADDR_W = 12;
  localparam int IDX_W  = 4;
  localparam int TRANSP = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sprite_line_buf.sv
// One sprite scanline buffer: single write port, registered read port.
module sprite_line_buf
  import sprite_line_fetch_pkg::*;
#(
  parameter int DEPTH = SPR_W,
  parameter int WIDTH = IDX_W
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sprite_line_fetch.sv
// Fetches one sprite scanline from ROM into a back buffer while the front
// buffer feeds per-pixel palette indices to the display.
module sprite_line_fetch #(
  parameter int SPR_W  = sprite_line_fetch_pkg::SPR_W,
  parameter int SPR_H  = sprite_line_fetch_pkg::SPR_H,
  parameter int ADDR_W = sprite_line_fetch_pkg::ADDR_W,
  parameter int IDX_W  = sprite_line_fetch_pkg::IDX_W,
  parameter int TRANSP = sprite_line_fetch_pkg::TRANSP
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [9:0]        line_y,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              flip,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              busy,
  output logic              done,
  input  logic [9:0]        pix_x,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_opaque
);

  import sprite_line_fetch_pkg::*;

  localparam int BUF_AW = $clog2(SPR_W);
  // One extra bit so col can reach SPR_W while the last ROM word drains.
  localparam int COL_W  = $clog2(SPR_W) + 1;

  state_t state_reg, state_next;

  logic [COL_W-1:0]  col_reg;
  logic [9:0]        row_reg;
  logic              front_sel_reg;
  logic              back_sel;
  logic [9:0]        x_reg [2];
  logic [1:0]        flip_reg;
  logic [1:0]        valid_reg;

  logic [9:0]        start_row;
  logic              in_range;

  logic              wr_en;
  logic [BUF_AW-1:0] wr_addr;

  logic [9:0]        front_x;
  logic [9:0]        pcol;
  logic              hit;
  logic [BUF_AW-1:0] rd_addr;
  logic              hit_reg;
  logic              rd_sel_reg;
  logic [IDX_W-1:0]  rd_q [2];
  logic [IDX_W-1:0]  buf_data;

  assign back_sel  = ~front_sel_reg;
  assign start_row = line_y - sprite_y;
  assign in_range  = (line_y >= sprite_y) && (int'(start_row) < SPR_H);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    rom_addr   = '0;
    case (state_reg)
      IDLE: begin
        if (line_start) begin
          state_next = in_range ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        rom_addr = ADDR_W'(row_reg) * ADDR_W'(SPR_W) + ADDR_W'(col_reg);
        if (col_reg == COL_W'(SPR_W - 1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The buffer being swapped out of display becomes the new fetch target.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_reg       <= '0;
      row_reg       <= '0;
      front_sel_reg <= 1'b0;
      x_reg[0]      <= '0;
      x_reg[1]      <= '0;
      flip_reg      <= '0;
      valid_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (line_start) begin
            front_sel_reg            <= back_sel;
            x_reg[front_sel_reg]     <= sprite_x;
            flip_reg[front_sel_reg]  <= flip;
            valid_reg[front_sel_reg] <= 1'b0;
            row_reg                  <= start_row;
            col_reg                  <= '0;
          end
        end
        ISSUE:   col_reg <= col_reg + COL_W'(1);
        DRAIN:   valid_reg[back_sel] <= 1'b1;
        default: ;
      endcase
    end
  end

  // ROM data lags its address by one clock, so each write lands at col-1.
  assign wr_en   = ((state_reg == ISSUE) && (col_reg != '0)) || (state_reg == DRAIN);
  assign wr_addr = BUF_AW'(col_reg - COL_W'(1));

  assign front_x = x_reg[front_sel_reg];
  assign pcol    = pix_x - front_x;
  assign hit     = (pix_x >= front_x) && (int'(pcol) < SPR_W) && valid_reg[front_sel_reg];
  assign rd_addr = flip_reg[front_sel_reg] ? BUF_AW'(SPR_W - 1 - int'(pcol))
                                           : BUF_AW'(pcol);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      sprite_line_buf #(
        .DEPTH(SPR_W),
        .WIDTH(IDX_W)
      ) u_buf (
        .clock  (clock),
        .wr_en  (wr_en && (back_sel == 1'(gi))),
        .wr_addr(wr_addr),
        .wr_data(rom_q),
        .rd_addr(rd_addr),
        .rd_data(rd_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_reg    <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      hit_reg    <= hit;
      rd_sel_reg <= front_sel_reg;
    end
  end

  assign buf_data   = rd_q[rd_sel_reg];
  assign pix_idx    = hit_reg ? buf_data : IDX_W'(TRANSP);
  assign pix_opaque = hit_reg && (buf_data != IDX_W'(TRANSP));

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed and randomized checks of sprite_line_fetch against a scanline model.
module tb_sprite_line_fetch;

  localparam int W = 64;
  localparam int H = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic [9:0]  sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic        flip = 1'b0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q = '0;
  logic        busy;
  logic        done;
  logic [9:0]  pix_x = '0;
  logic [3:0]  pix_idx;
  logic        pix_opaque;

  int compared = 0;
  int mismatched = 0;

  // Model: two scanlines, each with its own position, mirror and valid flag.
  int m_line [2][64];
  int m_x [2];
  int m_flip [2];
  int m_valid [2];
  int m_front = 0;

  sprite_line_fetch dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .line_start(line_start),
    .line_y    (line_y),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y),
    .flip      (flip),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .busy      (busy),
    .done      (done),
    .pix_x     (pix_x),
    .pix_idx   (pix_idx),
    .pix_opaque(pix_opaque)
  );

  always #5 clock = ~clock;

  function automatic int rom_val(input int a);
    return a & 15;
  endfunction

  always @(posedge clock) rom_q <= 4'(rom_val(int'(rom_addr)));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_pix(input int x, output int idx, output int opq);
    int f, pc, d;
    f   = m_front;
    idx = 0;
    opq = 0;
    if (m_valid[f] != 0 && x >= m_x[f] && x - m_x[f] < W) begin
      pc  = x - m_x[f];
      d   = m_line[f][(m_flip[f] != 0) ? (W - 1 - pc) : pc];
      idx = d;
      opq = (d != 0) ? 1 : 0;
    end
  endfunction

  task automatic step(input int x);
    int ei, eo;
    pix_x = 10'(x);
    model_pix(x, ei, eo);
    tick();
    chk("pix_idx", 32'(pix_idx), 32'(ei));
    chk("pix_opaque", 32'(pix_opaque), 32'(eo));
  endtask

  function automatic int pick_x();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023));
    return (m_x[m_front] + int'($urandom_range(0, 71)) - 4) & 1023;
  endfunction

  task automatic rnd_step();
    step(pick_x());
  endtask

  task automatic do_line(input int ly, input int sy, input int sx, input int fl,
                         input int stray_at, input int abort_at);
    int row, inr, b;
    row = (ly - sy) & 1023;
    inr = (ly >= sy && row < H) ? 1 : 0;
    line_y     = 10'(ly);
    sprite_y   = 10'(sy);
    sprite_x   = 10'(sx);
    flip       = (fl != 0);
    line_start = 1'b1;
    rnd_step();
    line_start = 1'b0;
    m_front    = 1 - m_front;
    b          = 1 - m_front;
    m_x[b]     = sx;
    m_flip[b]  = fl;
    m_valid[b] = 0;
    $display("line: y=%0d sprite_y=%0d row=%0d in_range=%0d sprite_x=%0d flip=%0d stray=%0d abort=%0d",
             ly, sy, row, inr, sx, fl, stray_at, abort_at);
    if (inr == 0) begin
      chk("oor_done", 32'(done), 32'd1);
      chk("oor_busy", 32'(busy), 32'd0);
      chk("oor_rom_addr", 32'(rom_addr), 32'd0);
      rnd_step();
      chk("oor_done_end", 32'(done), 32'd0);
      chk("oor_busy_end", 32'(busy), 32'd0);
      return;
    end
    for (int n = 0; n <= 66; n++) begin
      if (n > 0) begin
        line_start = (n == stray_at);
        rnd_step();
        line_start = 1'b0;
      end
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rom_addr", 32'(rom_addr), 32'd0);
        chk("abort_pix_idx", 32'(pix_idx), 32'd0);
        chk("abort_pix_opaque", 32'(pix_opaque), 32'd0);
        m_valid[0] = 0;
        m_valid[1] = 0;
        m_front    = 0;
        for (int k = 0; k < 3; k++) begin
          rnd_step();
          chk("abort_hold_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 70; k++) begin
          rnd_step();
          chk("abort_no_done", 32'(done), 32'd0);
          chk("abort_no_busy", 32'(busy), 32'd0);
        end
        return;
      end
      chk("busy", 32'(busy), 32'(n <= 64));
      chk("rom_addr", 32'(rom_addr), (n <= 63) ? 32'(row * W + n) : 32'd0);
      chk("done", 32'(done), 32'(n == 65));
    end
    for (int c = 0; c < W; c++) m_line[b][c] = rom_val(row * W + c);
    m_valid[b] = 1;
  endtask

  initial begin
    int sy, ly, r;
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0;
      m_flip[i] = 0;
      m_valid[i] = 0;
      for (int c = 0; c < W; c++) m_line[i][c] = 0;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix_idx", 32'(pix_idx), 32'd0);
    chk("rst_pix_opaque", 32'(pix_opaque), 32'd0);
    reset_n = 1'b1;
    repeat (2) rnd_step();

    // Fill at row 5 (addresses 320..383), then swap it to the front
    sy = int'($urandom_range(1, 900));
    do_line(sy + 5, sy, 100, 0, -1, -1);
    sy = int'($urandom_range(0, 900));
    do_line(sy + int'($urandom_range(0, 63)), sy, 100, 1, -1, -1);
    step(100);
    chk("d_x100_idx", 32'(pix_idx), 32'd0);
    chk("d_x100_opaque", 32'(pix_opaque), 32'd0);
    step(101);
    chk("d_x101_idx", 32'(pix_idx), 32'd1);
    chk("d_x101_opaque", 32'(pix_opaque), 32'd1);
    step(164);
    chk("d_x164_opaque", 32'(pix_opaque), 32'd0);

    // Line just above the sprite; front becomes the mirrored fill
    sy = int'($urandom_range(1, 900));
    do_line(sy - 1, sy, int'($urandom_range(0, 1023)), 0, -1, -1);
    step(100);
    chk("d_flip_x100_idx", 32'(pix_idx), 32'd15);
    step(163);
    chk("d_flip_x163_idx", 32'(pix_idx), 32'd0);

    // Line just below the sprite; front is now an empty line everywhere
    sy = int'($urandom_range(0, 959));
    do_line(sy + 64, sy, int'($urandom_range(0, 1023)), 1, -1, -1);
    for (int x = 0; x < 1024; x++) step(x);

    // Stray line_start mid-fetch, then a fetch aborted by reset
    sy = int'($urandom_range(0, 900));
    do_line(sy + int'($urandom_range(0, 63)), sy, int'($urandom_range(0, 960)),
            int'($urandom_range(0, 1)), 10, -1);
    sy = int'($urandom_range(0, 900));
    do_line(sy + int'($urandom_range(0, 63)), sy, int'($urandom_range(0, 960)),
            int'($urandom_range(0, 1)), -1, 30);

    // Randomized lines, mixing in-range, edge and out-of-range rows
    for (int t = 0; t < 10; t++) begin
      sy = int'($urandom_range(0, 1023));
      r  = int'($urandom_range(0, 3));
      if (r == 0) ly = int'($urandom_range(0, 1023));
      else if (r == 1) ly = (sy + 63 + int'($urandom_range(0, 2))) & 1023;
      else ly = (sy + int'($urandom_range(0, 63))) & 1023;
      do_line(ly, sy, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)), -1, -1);
      repeat (4) rnd_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
